// File: rtl/sram_cycle_pkg.sv
// Shared types and constants for the 68k-to-SRAM bus-cycle responder.
package sram_cycle_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ACCESS,
    ACK,
    RECOVER
  } state_t;

  localparam int unsigned CNT_W               = 4;
  localparam int unsigned WAIT_STATES_DEFAULT = 2;

  // One-hot low chip-enable pattern for a block index.
  function automatic logic [3:0] ce_mask(input logic [1:0] idx);
    ce_mask      = '1;
    ce_mask[idx] = 1'b0;
  endfunction

endpackage

// File: rtl/sram_cycle_responder_wait_counter.sv
// Loadable down-counter timing the ACCESS phase; zero flag ends the phase.
module sram_wait_counter
  import sram_cycle_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_value,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/sram_cycle_responder.sv
// Synchronous SRAM bus-cycle responder: strobes CE/OE/WE/UB/LB for a fixed
// number of wait states, captures read data and returns Dtack_L to the 68k.
module sram_cycle_responder
  import sram_cycle_pkg::*;
#(
  parameter int unsigned WAIT_STATES = WAIT_STATES_DEFAULT
) (
  input  logic        Clock,
  input  logic        Reset_H,
  input  logic        AS_L,
  input  logic        UDS_L,
  input  logic        LDS_L,
  input  logic        RW,
  input  logic [14:0] Address,
  input  logic [3:0]  Block_L,
  input  logic [15:0] DataIn,
  output logic [15:0] DataOut,
  output logic        Dtack_L,
  output logic [14:0] SRam_Addr,
  output logic [3:0]  SRam_CE_L,
  output logic        SRam_OE_L,
  output logic        SRam_WE_L,
  output logic        SRam_UB_L,
  output logic        SRam_LB_L,
  output logic [15:0] SRam_DataOut,
  output logic        SRam_DataOE_H,
  input  logic [15:0] SRam_DataIn
);

  state_t     state;
  logic       rw_q;
  logic       any_sel;
  logic [1:0] sel_idx;
  logic       start;
  logic       cnt_load;
  logic       cnt_dec;
  logic       cnt_zero;

  // Lowest-numbered selected block wins when the decoder asserts several.
  always_comb begin
    any_sel = 1'b0;
    sel_idx = 2'd0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!Block_L[i] && !any_sel) begin
        any_sel = 1'b1;
        sel_idx = 2'(i);
      end
    end
  end

  assign start    = !AS_L && any_sel && (!UDS_L || !LDS_L);
  assign cnt_load = (state == SETUP);
  assign cnt_dec  = (state == ACCESS);

  sram_wait_counter u_wait (
    .clk        (Clock),
    .rst        (Reset_H),
    .load       (cnt_load),
    .dec        (cnt_dec),
    .load_value (CNT_W'(WAIT_STATES - 1)),
    .zero       (cnt_zero)
  );

  // Controls are written from the next state so each one changes on the same
  // edge as the transition; Dtack follows one clock into ACK.
  always_ff @(posedge Clock or posedge Reset_H) begin
    if (Reset_H) begin
      state         <= IDLE;
      rw_q          <= 1'b1;
      DataOut       <= '0;
      Dtack_L       <= 1'b1;
      SRam_Addr     <= '0;
      SRam_CE_L     <= '1;
      SRam_OE_L     <= 1'b1;
      SRam_WE_L     <= 1'b1;
      SRam_UB_L     <= 1'b1;
      SRam_LB_L     <= 1'b1;
      SRam_DataOut  <= '0;
      SRam_DataOE_H <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state         <= SETUP;
            rw_q          <= RW;
            SRam_Addr     <= Address;
            SRam_DataOut  <= DataIn;
            SRam_CE_L     <= ce_mask(sel_idx);
            SRam_UB_L     <= UDS_L;
            SRam_LB_L     <= LDS_L;
            SRam_OE_L     <= !RW;
            SRam_DataOE_H <= !RW;
          end
        end
        SETUP, ACCESS: begin
          if (AS_L) begin
            state         <= RECOVER;
            SRam_CE_L     <= '1;
            SRam_OE_L     <= 1'b1;
            SRam_WE_L     <= 1'b1;
            SRam_UB_L     <= 1'b1;
            SRam_LB_L     <= 1'b1;
            SRam_DataOE_H <= 1'b0;
          end else if (state == SETUP) begin
            state     <= ACCESS;
            SRam_WE_L <= rw_q;
          end else if (cnt_zero) begin
            state     <= ACK;
            SRam_CE_L <= '1;
            SRam_OE_L <= 1'b1;
            SRam_WE_L <= 1'b1;
            SRam_UB_L <= 1'b1;
            SRam_LB_L <= 1'b1;
            if (rw_q) begin
              DataOut <= SRam_DataIn;
            end
          end
        end
        ACK: begin
          if (AS_L) begin
            state         <= RECOVER;
            Dtack_L       <= 1'b1;
            SRam_DataOE_H <= 1'b0;
          end else begin
            Dtack_L <= 1'b0;
          end
        end
        RECOVER: begin
          state         <= IDLE;
          Dtack_L       <= 1'b1;
          SRam_DataOE_H <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_cycle_responder.sv
// Self-checking bench: directed and random 68k cycles against a memory-level
// reference model, with extra instances at WAIT_STATES=1 and 15 for latency.
module tb_sram_cycle_responder;

  logic        Clock = 1'b0;
  logic        Reset_H;
  logic        AS_L, UDS_L, LDS_L, RW;
  logic [14:0] Address;
  logic [3:0]  Block_L;
  logic [15:0] DataIn;
  logic [15:0] sram_rdata;

  logic [15:0] data_out, sram_wdata;
  logic [14:0] sram_addr;
  logic [3:0]  ce_l;
  logic        dtack_l, oe_l, we_l, ub_l, lb_l, data_oe;

  logic [15:0] d1_data_out, d1_wdata;
  logic [14:0] d1_addr;
  logic [3:0]  d1_ce_l;
  logic        d1_dtack_l, d1_oe_l, d1_we_l, d1_ub_l, d1_lb_l, d1_data_oe;

  logic [15:0] d15_data_out, d15_wdata;
  logic [14:0] d15_addr;
  logic [3:0]  d15_ce_l;
  logic        d15_dtack_l, d15_oe_l, d15_we_l, d15_ub_l, d15_lb_l, d15_data_oe;

  int checks   = 0;
  int failures = 0;

  logic [15:0] sram_mem [int];
  logic [15:0] exp_mem  [int];
  logic [15:0] exp_data_out;

  always #5 Clock = ~Clock;

  sram_cycle_responder #(.WAIT_STATES(2)) dut (
    .Clock(Clock), .Reset_H(Reset_H), .AS_L(AS_L), .UDS_L(UDS_L), .LDS_L(LDS_L),
    .RW(RW), .Address(Address), .Block_L(Block_L), .DataIn(DataIn),
    .DataOut(data_out), .Dtack_L(dtack_l), .SRam_Addr(sram_addr), .SRam_CE_L(ce_l),
    .SRam_OE_L(oe_l), .SRam_WE_L(we_l), .SRam_UB_L(ub_l), .SRam_LB_L(lb_l),
    .SRam_DataOut(sram_wdata), .SRam_DataOE_H(data_oe), .SRam_DataIn(sram_rdata)
  );

  sram_cycle_responder #(.WAIT_STATES(1)) dut_ws1 (
    .Clock(Clock), .Reset_H(Reset_H), .AS_L(AS_L), .UDS_L(UDS_L), .LDS_L(LDS_L),
    .RW(RW), .Address(Address), .Block_L(Block_L), .DataIn(DataIn),
    .DataOut(d1_data_out), .Dtack_L(d1_dtack_l), .SRam_Addr(d1_addr), .SRam_CE_L(d1_ce_l),
    .SRam_OE_L(d1_oe_l), .SRam_WE_L(d1_we_l), .SRam_UB_L(d1_ub_l), .SRam_LB_L(d1_lb_l),
    .SRam_DataOut(d1_wdata), .SRam_DataOE_H(d1_data_oe), .SRam_DataIn(16'h5A5A)
  );

  sram_cycle_responder #(.WAIT_STATES(15)) dut_ws15 (
    .Clock(Clock), .Reset_H(Reset_H), .AS_L(AS_L), .UDS_L(UDS_L), .LDS_L(LDS_L),
    .RW(RW), .Address(Address), .Block_L(Block_L), .DataIn(DataIn),
    .DataOut(d15_data_out), .Dtack_L(d15_dtack_l), .SRam_Addr(d15_addr), .SRam_CE_L(d15_ce_l),
    .SRam_OE_L(d15_oe_l), .SRam_WE_L(d15_we_l), .SRam_UB_L(d15_ub_l), .SRam_LB_L(d15_lb_l),
    .SRam_DataOut(d15_wdata), .SRam_DataOE_H(d15_data_oe), .SRam_DataIn(16'hC3C3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic int lowest_block(input logic [3:0] bl);
    for (int i = 0; i < 4; i++) if (!bl[i]) return i;
    return -1;
  endfunction

  function automatic int mem_key(input int blk, input logic [14:0] a);
    return blk * 32768 + int'(a);
  endfunction

  // Behavioural SRAM on the main instance: writes while WE is low, read data
  // presented from the current address/chip-enable.
  always @(negedge Clock) begin
    int b;
    int k;
    logic [15:0] w;
    b = -1;
    for (int i = 0; i < 4; i++) if (!ce_l[i] && b < 0) b = i;
    k = mem_key(b, sram_addr);
    if (!we_l) begin
      checks++;
      assert (b >= 0 && $countones(~ce_l) == 1 && data_oe === 1'b1) else begin
        failures++;
        $error("FAIL we_in_ce_window: observed ce=%h oe_h=%b expected one-hot ce and oe_h=1", ce_l, data_oe);
      end
      if (b >= 0) begin
        w = sram_mem.exists(k) ? sram_mem[k] : 16'h0000;
        if (!ub_l) w[15:8] = sram_wdata[15:8];
        if (!lb_l) w[7:0]  = sram_wdata[7:0];
        sram_mem[k] = w;
      end
    end
    sram_rdata <= (b >= 0 && sram_mem.exists(k)) ? sram_mem[k] : 16'h0000;
  end

  task automatic run_cycle(input logic [3:0] bl, input logic [14:0] addr, input logic rw,
                           input logic uds, input logic lds, input logic [15:0] wd,
                           input int ds_delay, input int abort_j, input int hold,
                           input bit wait_all, input string tag);
    int blk, k, d2_j, d1_j, d15_j, ce_n, ce_bad, oe_n, we_n;
    logic [3:0] ce_exp;
    logic [15:0] w;
    blk = lowest_block(bl);
    ce_exp = 4'hF;
    ce_exp[blk] = 1'b0;
    d2_j = -1; d1_j = -1; d15_j = -1;
    ce_n = 0; ce_bad = 0; oe_n = 0; we_n = 0;

    @(negedge Clock);
    AS_L = 1'b0; Block_L = bl; Address = addr; RW = rw; DataIn = wd;
    UDS_L = (ds_delay > 0) ? 1'b1 : uds;
    LDS_L = (ds_delay > 0) ? 1'b1 : lds;
    for (int i = 0; i < ds_delay; i++) begin
      @(negedge Clock);
      check({tag, "_ds_wait_ce"}, 32'(ce_l), 32'hF);
    end
    UDS_L = uds; LDS_L = lds;

    for (int j = 0; j <= 40; j++) begin
      @(negedge Clock);
      if (j == 0) begin
        check({tag, "_addr"}, 32'(sram_addr), 32'(addr));
        check({tag, "_ub"}, 32'(ub_l), 32'(uds));
        check({tag, "_lb"}, 32'(lb_l), 32'(lds));
        if (!rw) check({tag, "_setup_data_oe"}, 32'(data_oe), 32'd1);
      end
      if (ce_l == ce_exp) ce_n++;
      else if (ce_l != 4'hF) ce_bad++;
      if (!oe_l) oe_n++;
      if (!we_l) we_n++;
      if (!dtack_l && d2_j < 0) begin
        d2_j = j;
        if (!rw) begin
          check({tag, "_ack_wdata"}, 32'(sram_wdata), 32'(wd));
          check({tag, "_ack_data_oe"}, 32'(data_oe), 32'd1);
        end
      end
      if (!d1_dtack_l && d1_j < 0) d1_j = j;
      if (!d15_dtack_l && d15_j < 0) d15_j = j;
      if (abort_j == j) break;
      if (wait_all ? (d2_j >= 0 && d1_j >= 0 && d15_j >= 0) : (d2_j >= 0)) break;
    end

    if (abort_j < 0) begin
      for (int i = 0; i < hold; i++) begin
        @(negedge Clock);
        check({tag, "_dtack_hold"}, 32'(dtack_l), 32'd0);
      end
    end
    AS_L = 1'b1; UDS_L = 1'b1; LDS_L = 1'b1;
    @(negedge Clock);
    check({tag, "_release_dtack"}, 32'(dtack_l), 32'd1);
    check({tag, "_release_ctrl"}, {data_oe, oe_l, we_l, ce_l}, {1'b0, 1'b1, 1'b1, 4'hF});

    if (abort_j >= 0) begin
      check({tag, "_abort_no_dtack"}, 32'(d2_j), 32'hFFFF_FFFF);
      check({tag, "_abort_oe_cycles"}, 32'(oe_n), 32'(rw ? abort_j + 1 : 0));
    end else begin
      check({tag, "_dtack_latency"}, 32'(d2_j), 32'd4);
      check({tag, "_ce_cycles"}, 32'(ce_n), 32'd3);
      check({tag, "_ce_bad"}, 32'(ce_bad), 32'd0);
      check({tag, "_oe_cycles"}, 32'(oe_n), rw ? 32'd3 : 32'd0);
      check({tag, "_we_cycles"}, 32'(we_n), rw ? 32'd0 : 32'd2);
      k = mem_key(blk, addr);
      if (rw) begin
        exp_data_out = exp_mem.exists(k) ? exp_mem[k] : 16'h0000;
      end else begin
        w = exp_mem.exists(k) ? exp_mem[k] : 16'h0000;
        if (!uds) w[15:8] = wd[15:8];
        if (!lds) w[7:0]  = wd[7:0];
        exp_mem[k] = w;
      end
    end
    check({tag, "_data_out"}, 32'(data_out), 32'(exp_data_out));
    if (wait_all) begin
      check({tag, "_ws1_latency"}, 32'(d1_j), 32'd3);
      check({tag, "_ws15_latency"}, 32'(d15_j), 32'd17);
      check({tag, "_ws1_data"}, 32'(d1_data_out), 32'h5A5A);
      check({tag, "_ws15_data"}, 32'(d15_data_out), 32'hC3C3);
    end
  endtask

  initial begin
    int bl_ok, ce_seen_bad, dt_seen;
    logic [3:0]  bl;
    logic        rw, uds, lds;
    int          sel, abort_j;

    Reset_H = 1'b1; AS_L = 1'b1; UDS_L = 1'b1; LDS_L = 1'b1; RW = 1'b1;
    Address = '0; Block_L = 4'hF; DataIn = '0; exp_data_out = '0;
    #12;
    check("reset_ctrl", {dtack_l, ce_l, oe_l, we_l, ub_l, lb_l, data_oe},
          {1'b1, 4'hF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0});
    check("reset_data_out", 32'(data_out), 32'h0);
    check("reset_addr_wdata", {sram_addr, sram_wdata}, 32'h0);
    @(negedge Clock);
    Reset_H = 1'b0;

    // Reset in the middle of a write ACCESS phase.
    @(negedge Clock);
    AS_L = 1'b0; Block_L = 4'b0111; Address = 15'h7FFF; RW = 1'b0;
    UDS_L = 1'b0; LDS_L = 1'b0; DataIn = 16'h1234;
    @(negedge Clock);
    @(negedge Clock);
    check("rst_mid_we_active", 32'(we_l), 32'd0);
    #2 Reset_H = 1'b1;
    #1 check("rst_mid_ctrl_off", {we_l, ce_l, data_oe, dtack_l}, {1'b1, 4'hF, 1'b0, 1'b1});
    @(negedge Clock);
    Reset_H = 1'b0; AS_L = 1'b1; UDS_L = 1'b1; LDS_L = 1'b1; Block_L = 4'hF;
    exp_data_out = 16'h0000;

    sram_mem[mem_key(1, 15'h1234)] = 16'hBEEF;
    exp_mem[mem_key(1, 15'h1234)]  = 16'hBEEF;
    run_cycle(4'b1101, 15'h1234, 1'b1, 1'b0, 1'b0, 16'h0000, 0, -1, 1, 1'b0, "read_beef");
    run_cycle(4'b1110, 15'h0010, 1'b0, 1'b0, 1'b1, 16'hA500, 1, -1, 2, 1'b0, "write_a500");
    run_cycle(4'b1110, 15'h0010, 1'b1, 1'b0, 1'b0, 16'h0000, 0, -1, 0, 1'b0, "readback_a500");
    run_cycle(4'b1101, 15'h1234, 1'b1, 1'b0, 1'b0, 16'h0000, 0, -1, 0, 1'b0, "reread_beef");
    run_cycle(4'b1011, 15'h0003, 1'b1, 1'b0, 1'b0, 16'h0000, 0, 1, 0, 1'b0, "abort_access");

    // No block selected: must stay idle.
    @(negedge Clock);
    AS_L = 1'b0; Block_L = 4'hF; RW = 1'b1; UDS_L = 1'b0; LDS_L = 1'b0;
    ce_seen_bad = 0; dt_seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge Clock);
      if (ce_l != 4'hF) ce_seen_bad++;
      if (!dtack_l) dt_seen++;
    end
    check("no_block_ce", 32'(ce_seen_bad), 32'd0);
    check("no_block_dtack", 32'(dt_seen), 32'd0);
    AS_L = 1'b1; UDS_L = 1'b1; LDS_L = 1'b1;
    @(negedge Clock);

    run_cycle(4'b1100, 15'h0005, 1'b1, 1'b0, 1'b0, 16'h0000, 0, -1, 0, 1'b1, "multi_block_latency");

    for (int n = 0; n < 40; n++) begin
      bl_ok = $urandom_range(0, 14);
      bl    = 4'(bl_ok);
      rw    = 1'($urandom_range(0, 1));
      sel   = $urandom_range(0, 2);
      uds   = (sel == 2);
      lds   = (sel == 1);
      abort_j = (rw && $urandom_range(0, 7) == 0) ? $urandom_range(0, 2) : -1;
      run_cycle(bl, 15'($urandom_range(0, 7)), rw, uds, lds, 16'($urandom),
                rw ? 0 : $urandom_range(0, 1), abort_j, $urandom_range(0, 3), 1'b0,
                $sformatf("rand%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
